// File: rtl/simd_rf_write_arbiter.sv
// Merges scalar and 4-lane SIMD writebacks into one registered SIMD regfile write per cycle.
// SIMD results wait in a 2-entry FIFO; a saturating loss counter bounds how long the head can starve.
module simd_rf_write_arbiter #(
  parameter int width_p        = 33,
  parameter int els_p          = 32,
  parameter int starve_limit_p = 4,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            scalar_v_i,
  input  logic [addr_width_lp-1:0]        scalar_addr_i,
  input  logic [width_p-1:0]              scalar_data_i,
  output logic                            scalar_yumi_o,
  input  logic                            simd_v_i,
  input  logic [addr_width_lp-1:0]        simd_addr_i,
  input  logic [3:0]                      simd_mask_i,
  input  logic [3:0][width_p-1:0]         simd_data_i,
  output logic                            simd_ready_o,
  output logic [3:0]                      w_v_o,
  output logic [addr_width_lp-1:0]        w_addr_o,
  output logic [3:0][width_p-1:0]         w_data_o,
  output logic                            simd_pending_o
);

  localparam int GW = addr_width_lp - 2;
  localparam int SW = $clog2(starve_limit_p + 1);
  localparam logic [SW-1:0] LIMIT = SW'(starve_limit_p);

  logic [GW-1:0]              grp_mem  [2];
  logic [3:0]                 mask_mem [2];
  logic [3:0][width_p-1:0]    data_mem [2];
  logic                       rd_ptr_r, wr_ptr_r;
  logic [1:0]                 count_r;
  logic [SW-1:0]              starve_r;

  logic                       h_v, enq, deq, grant_s, grant_h;
  logic [GW-1:0]              head_grp, s_grp;
  logic [3:0]                 head_mask, s_onehot;
  logic [3:0][width_p-1:0]    head_data;
  logic [1:0]                 s_lane;
  logic [3:0]                 nxt_v;
  logic [addr_width_lp-1:0]   nxt_addr;
  logic [3:0][width_p-1:0]    nxt_data;

  assign h_v       = (count_r != 2'd0);
  assign head_grp  = grp_mem[rd_ptr_r];
  assign head_mask = mask_mem[rd_ptr_r];
  assign head_data = data_mem[rd_ptr_r];
  assign s_lane    = scalar_addr_i[1:0];
  assign s_grp     = scalar_addr_i[addr_width_lp-1:2];
  assign s_onehot  = 4'b0001 << s_lane;

  assign simd_ready_o   = !reset_i && (count_r != 2'd2);
  assign enq            = simd_v_i && simd_ready_o;
  assign simd_pending_o = h_v;
  assign scalar_yumi_o  = grant_s;

  // Arbitration stage: pick scalar, head, or a same-group merge of both
  always_comb begin
    grant_s = 1'b0;
    grant_h = 1'b0;
    deq     = 1'b0;
    if (reset_i) begin
      grant_s = 1'b0;
    end else if (h_v && (head_mask == 4'b0000)) begin
      deq     = 1'b1;
      grant_s = scalar_v_i;
    end else if (scalar_v_i && h_v) begin
      if ((s_grp == head_grp) && ((head_mask & s_onehot) == 4'b0000)) begin
        grant_s = 1'b1;
        grant_h = 1'b1;
        deq     = 1'b1;
      end else if (s_grp == head_grp) begin
        // Same register in both: scalar must land first so the SIMD value is final
        grant_s = 1'b1;
      end else if (starve_r == LIMIT) begin
        grant_h = 1'b1;
        deq     = 1'b1;
      end else begin
        grant_s = 1'b1;
      end
    end else if (scalar_v_i) begin
      grant_s = 1'b1;
    end else if (h_v) begin
      grant_h = 1'b1;
      deq     = 1'b1;
    end
  end

  always_comb begin
    nxt_v    = (grant_h ? head_mask : 4'b0000) | (grant_s ? s_onehot : 4'b0000);
    nxt_addr = grant_h ? {head_grp, 2'b00} : scalar_addr_i;
    nxt_data = head_data;
    if (grant_s) nxt_data[s_lane] = scalar_data_i;
  end

  // Register stage: FIFO control, starvation counter, regfile write port
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      starve_r <= '0;
      w_v_o    <= 4'b0000;
      w_addr_o <= '0;
      w_data_o <= '0;
    end else begin
      if (enq) wr_ptr_r <= ~wr_ptr_r;
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (deq || !h_v)          starve_r <= '0;
      else if (starve_r != LIMIT) starve_r <= starve_r + SW'(1);
      w_v_o <= nxt_v;
      if (grant_s || grant_h) begin
        w_addr_o <= nxt_addr;
        w_data_o <= nxt_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      grp_mem[wr_ptr_r]  <= simd_addr_i[addr_width_lp-1:2];
      mask_mem[wr_ptr_r] <= simd_mask_i;
      data_mem[wr_ptr_r] <= simd_data_i;
    end
  end

endmodule

// File: tb/tb_simd_rf_write_arbiter.sv
// Directed bench for simd_rf_write_arbiter: scalar, SIMD, merge, starvation, backpressure, reset.
module tb_simd_rf_write_arbiter;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                scalar_v_i;
  logic [4:0]          scalar_addr_i;
  logic [32:0]         scalar_data_i;
  logic                scalar_yumi_o;
  logic                simd_v_i;
  logic [4:0]          simd_addr_i;
  logic [3:0]          simd_mask_i;
  logic [3:0][32:0]    simd_data_i;
  logic                simd_ready_o;
  logic [3:0]          w_v_o;
  logic [4:0]          w_addr_o;
  logic [3:0][32:0]    w_data_o;
  logic                simd_pending_o;

  int n_cmp = 0;
  int n_err = 0;

  simd_rf_write_arbiter #(.width_p(33), .els_p(32), .starve_limit_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .scalar_v_i(scalar_v_i), .scalar_addr_i(scalar_addr_i), .scalar_data_i(scalar_data_i),
    .scalar_yumi_o(scalar_yumi_o),
    .simd_v_i(simd_v_i), .simd_addr_i(simd_addr_i), .simd_mask_i(simd_mask_i),
    .simd_data_i(simd_data_i), .simd_ready_o(simd_ready_o),
    .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o), .simd_pending_o(simd_pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [3:0] m, input logic [32:0] base);
    simd_v_i    = 1'b1;
    simd_addr_i = a;
    simd_mask_i = m;
    for (int i = 0; i < 4; i++) simd_data_i[i] = base + 33'(i);
  endtask

  task automatic scal(input logic [4:0] a, input logic [32:0] d);
    scalar_v_i    = 1'b1;
    scalar_addr_i = a;
    scalar_data_i = d;
  endtask

  initial begin
    reset_i = 1'b1;
    scalar_v_i = 1'b0; scalar_addr_i = '0; scalar_data_i = '0;
    simd_v_i = 1'b0; simd_addr_i = '0; simd_mask_i = '0; simd_data_i = '0;

    // reset
    tick(); tick();
    check("rst_ready", 64'(simd_ready_o), 64'd0);
    reset_i = 1'b0;
    #1;
    check("rst_w_v", 64'(w_v_o), 64'd0);
    check("rst_w_addr", 64'(w_addr_o), 64'd0);
    check("rst_pending", 64'(simd_pending_o), 64'd0);
    check("rst_ready_after", 64'(simd_ready_o), 64'd1);

    // 1. scalar only
    scal(5'd6, 33'h1_2345_6789);
    #1 check("t1_yumi", 64'(scalar_yumi_o), 64'd1);
    tick();
    scalar_v_i = 1'b0;
    check("t1_w_v", 64'(w_v_o), 64'b0100);
    check("t1_w_addr", 64'(w_addr_o), 64'd6);
    check("t1_w_data2", 64'(w_data_o[2]), 64'h1_2345_6789);

    // 2. SIMD only
    push(5'd9, 4'b1011, 33'h0_0000_0A00);
    #1 check("t2_ready", 64'(simd_ready_o), 64'd1);
    check("t2_pend_t", 64'(simd_pending_o), 64'd0);
    tick();
    simd_v_i = 1'b0;
    check("t2_pend_t1", 64'(simd_pending_o), 64'd1);
    check("t2_w_v_t1", 64'(w_v_o), 64'd0);
    tick();
    check("t2_w_v", 64'(w_v_o), 64'b1011);
    check("t2_w_addr", 64'(w_addr_o), 64'd8);
    check("t2_w_data0", 64'(w_data_o[0]), 64'h0A00);
    check("t2_w_data3", 64'(w_data_o[3]), 64'h0A03);
    check("t2_pend_t2", 64'(simd_pending_o), 64'd0);

    // 3. merge
    push(5'd16, 4'b0011, 33'h0_0000_0B00);
    tick();
    simd_v_i = 1'b0;
    scal(5'd18, 33'h1_0000_0018);
    #1 check("t3_yumi", 64'(scalar_yumi_o), 64'd1);
    tick();
    scalar_v_i = 1'b0;
    check("t3_w_v", 64'(w_v_o), 64'b0111);
    check("t3_w_addr", 64'(w_addr_o), 64'd16);
    check("t3_w_data0", 64'(w_data_o[0]), 64'h0B00);
    check("t3_w_data1", 64'(w_data_o[1]), 64'h0B01);
    check("t3_w_data2", 64'(w_data_o[2]), 64'h1_0000_0018);
    check("t3_pending", 64'(simd_pending_o), 64'd0);

    // 4. starvation
    push(5'd0, 4'b1111, 33'h0_0000_0C00);
    tick();
    simd_v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scal(5'(4 + k), 33'h0_0000_0D00 + 33'(k));
      #1 check("t4_yumi_s", 64'(scalar_yumi_o), 64'd1);
      tick();
      check("t4_w_v_s", 64'(w_v_o), 64'(4'b0001 << k));
      check("t4_w_addr_s", 64'(w_addr_o), 64'(4 + k));
    end
    scal(5'd5, 33'h0_0000_0E05);
    #1 check("t4_yumi_h", 64'(scalar_yumi_o), 64'd0);
    tick();
    check("t4_w_v_h", 64'(w_v_o), 64'b1111);
    check("t4_w_addr_h", 64'(w_addr_o), 64'd0);
    check("t4_pend_h", 64'(simd_pending_o), 64'd0);
    check("t4_yumi_late", 64'(scalar_yumi_o), 64'd1);
    tick();
    scalar_v_i = 1'b0;
    check("t4_w_v_late", 64'(w_v_o), 64'b0010);
    check("t4_w_data_late", 64'(w_data_o[1]), 64'h0E05);

    // 5. backpressure
    scal(5'd28, 33'h0_0000_0F00);
    push(5'd8, 4'b1001, 33'h0_0000_1000);
    #1 check("t5_ready_a", 64'(simd_ready_o), 64'd1);
    tick();
    push(5'd12, 4'b0010, 33'h0_0000_2000);
    #1 check("t5_ready_b", 64'(simd_ready_o), 64'd1);
    check("t5_yumi_b", 64'(scalar_yumi_o), 64'd1);
    tick();
    push(5'd20, 4'b0100, 33'h0_0000_3000);
    for (int k = 0; k < 3; k++) begin
      #1 check("t5_ready_full", 64'(simd_ready_o), 64'd0);
      check("t5_yumi_full", 64'(scalar_yumi_o), 64'd1);
      tick();
      check("t5_w_v_s", 64'(w_v_o), 64'b0001);
    end
    #1 check("t5_ready_f", 64'(simd_ready_o), 64'd0);
    check("t5_yumi_f", 64'(scalar_yumi_o), 64'd0);
    tick();
    check("t5_w_v_p1", 64'(w_v_o), 64'b1001);
    check("t5_w_addr_p1", 64'(w_addr_o), 64'd8);
    scalar_v_i = 1'b0;
    #1 check("t5_ready_g", 64'(simd_ready_o), 64'd1);
    tick();
    simd_v_i = 1'b0;
    check("t5_w_v_p2", 64'(w_v_o), 64'b0010);
    check("t5_w_addr_p2", 64'(w_addr_o), 64'd12);
    check("t5_pend_g", 64'(simd_pending_o), 64'd1);
    tick();
    check("t5_w_v_p3", 64'(w_v_o), 64'b0100);
    check("t5_w_addr_p3", 64'(w_addr_o), 64'd20);
    check("t5_w_data_p3", 64'(w_data_o[2]), 64'h3002);
    check("t5_pend_end", 64'(simd_pending_o), 64'd0);

    // 6. reset mid-stream
    scal(5'd28, 33'h0_0000_4000);
    push(5'd24, 4'b1111, 33'h0_0000_5000);
    tick();
    push(5'd24, 4'b0110, 33'h0_0000_6000);
    #1 check("t6_ready_b", 64'(simd_ready_o), 64'd1);
    tick();
    check("t6_w_v_pre", 64'(w_v_o), 64'b0001);
    check("t6_pend_pre", 64'(simd_pending_o), 64'd1);
    check("t6_full", 64'(simd_ready_o), 64'd0);
    scalar_v_i = 1'b0;
    simd_v_i   = 1'b0;
    reset_i    = 1'b1;
    #1 check("t6_ready_rst", 64'(simd_ready_o), 64'd0);
    check("t6_yumi_rst", 64'(scalar_yumi_o), 64'd0);
    tick();
    reset_i = 1'b0;
    check("t6_w_v", 64'(w_v_o), 64'd0);
    check("t6_w_addr", 64'(w_addr_o), 64'd0);
    check("t6_w_data0", 64'(w_data_o[0]), 64'd0);
    check("t6_w_data3", 64'(w_data_o[3]), 64'd0);
    check("t6_pending", 64'(simd_pending_o), 64'd0);
    #1 check("t6_ready", 64'(simd_ready_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_no_drop_write", 64'(w_v_o), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
